// File: rtl/grant_capture_fifo_pkg.sv
// rtl/grant_capture_fifo_pkg.sv - shared grant decode defaults and helpers for the arbiter datapath
package grant_capture_fifo_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // True when exactly one bit of the (zero-extended) grant vector is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // True when two or more grant bits are set.
    function automatic logic is_multihot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) != 32'd0);
    endfunction

    // Index of the lowest set bit, matching the arbiter's fixed priority (bit 0 highest).
    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_capture_fifo_sync_fifo_fwft.sv
// rtl/grant_capture_fifo_sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO
module sync_fifo_fwft #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; a write into the slot being popped while full is safe
    // because the head was already read combinationally this cycle.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/grant_capture_fifo.sv
// rtl/grant_capture_fifo.sv - captures granted requester words into a FIFO with ack and error flag
module grant_capture_fifo
    import grant_capture_fifo_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        gnt,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic [CNT_W-1:0]        count,
    output logic                    err
);

    logic [N_REQ-1:0]        ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    gnt_onehot;
    logic                    gnt_multi;
    logic [SRC_W-1:0]        gnt_idx;
    logic [DATA_W-1:0]       win_data;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SRC_W+DATA_W-1:0] head;

    // Grant decode and winner data mux; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        gnt_onehot = is_onehot(32'(gnt));
        gnt_multi  = is_multihot(32'(gnt));
        gnt_idx    = SRC_W'(onehot_idx(32'(gnt)));
        win_data   = req_data[gnt_idx*DATA_W +: DATA_W];
        pop        = !fifo_empty && out_ready;
        push       = gnt_onehot && (!fifo_full || pop);
        ack_d      = push ? gnt : '0;
        err_d      = err_q || gnt_multi;
    end

    // Ack pulse to the stored winner one cycle after its grant; sticky error on multi-hot grants.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q <= '0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (SRC_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (push),
        .wr_data_i ({gnt_idx, win_data}),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = fifo_full;
    assign out_valid = !fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_src   = head[SRC_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_grant_capture_fifo.sv
// tb/tb_grant_capture_fifo.sv - scoreboard bench for grant_capture_fifo
module tb_grant_capture_fifo;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  gnt = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [3:0]  count;
    logic        err;

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   mcount = 0;
    logic merr = 1'b0;
    int   checks = 0;
    int   passes = 0;

    grant_capture_fifo #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .gnt       (gnt),
        .req_data  (req_data),
        .ack       (ack),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT hands an entry over, it must be the oldest expected one.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL pop_unexpected actual=%0h required=none at %0t", out_data, $time);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_src", 32'(out_src), 32'(e.src));
                chk("pop_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    // One clock of stimulus; the reference model decides what should happen from the rules alone.
    task automatic step(input logic [3:0] g, input logic [31:0] d, input logic rdy);
        logic       pop_m, push_m;
        logic [3:0] exp_ack;
        ent_t       e;
        int         k;
        gnt       = g;
        req_data  = d;
        out_ready = rdy;
        pop_m  = (mcount > 0) && rdy;
        push_m = ($countones(g) == 1) && ((mcount < DEPTH) || pop_m);
        if (push_m) begin
            k = $clog2(g);
            e.src  = 2'(k);
            e.data = d[k*8 +: 8];
            exp_q.push_back(e);
        end
        exp_ack = push_m ? g : 4'b0000;
        if ($countones(g) > 1) merr = 1'b1;
        mcount = mcount + int'(push_m) - int'(pop_m);
        @(posedge clk);
        #2;
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("count", 32'(count), 32'(mcount));
        chk("busy", 32'(busy), 32'(mcount == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mcount > 0));
        chk("err", 32'(err), 32'(merr));
        if (mcount > 0 && exp_q.size() > 0) begin
            chk("head_src", 32'(out_src), 32'(exp_q[0].src));
            chk("head_data", 32'(out_data), 32'(exp_q[0].data));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        gnt = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        mcount = 0;
        merr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #1;
    endtask

    function automatic logic [3:0] rand_gnt();
        int r, a, b;
        r = $urandom_range(0, 19);
        if (r < 4) return 4'b0000;
        a = $urandom_range(0, 3);
        if (r < 19) return 4'(1 << a);
        b = (a + 1 + $urandom_range(0, 2)) % 4;
        return 4'((1 << a) | (1 << b));
    endfunction

    initial begin
        // 1: reset state
        @(posedge clk);
        do_reset();

        // 2: single grant to requester 2
        step(4'b0100, 32'h00A5_0000, 1'b0);
        chk("t2_data", 32'(out_data), 32'hA5);
        chk("t2_src", 32'(out_src), 32'd2);

        // 3: fill to full, grant while full is dropped, grant with pop is accepted
        do_reset();
        for (int i = 0; i < 8; i++) step(4'(1 << (i % 4)), $urandom(), 1'b0);
        step(4'b0001, $urandom(), 1'b0);
        step(4'b0001, $urandom(), 1'b1);

        // 4: multi-hot grant sets sticky error
        step(4'b0110, $urandom(), 1'b0);
        step(4'b0000, $urandom(), 1'b1);
        step(4'b0010, $urandom(), 1'b1);

        // 5: round-robin fill and drain across pointer wrap
        do_reset();
        for (int i = 0; i < 5; i++) step(4'(1 << (i % 4)), $urandom(), 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0000, $urandom(), 1'b1);
        for (int i = 0; i < 8; i++) step(4'(1 << (i % 4)), $urandom(), 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0000, $urandom(), 1'b1);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) step(rand_gnt(), $urandom(), 1'($urandom_range(0, 2) == 0 ? 0 : 1) & 1'(i % 97 > 30 || i < 200));

        // 6: asynchronous reset with count 5 and a grant in the same cycle
        do_reset();
        for (int i = 0; i < 5; i++) step(4'(1 << (i % 4)), $urandom(), 1'b0);
        gnt = 4'b0001;
        req_data = $urandom();
        reset = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        chk("t6_ack_after", 32'(ack), 32'd0);
        do_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
